// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : muldiv_pkg                                                    |
// | Purpose    : Shared constants and types for the multiply/divide unit:      |
// |              op encoding, FSM state type, accumulator width helper.        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // The shift-add / restoring-divide accumulator holds {HI, LO}.
  function automatic int acc_width(input int w);
    return 2 * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : muldiv_sign_fix                                               |
// | Purpose    : Combinational sign handling. Front half turns operands into   |
// |              magnitudes for signed ops; back half conditionally negates    |
// |              the result either as one 2*WIDTH product or as independent    |
// |              quotient (lo) / remainder (hi) halves.                        |
// | Ports      : a_i/b_i/is_signed_i -> a_abs_o/b_abs_o                         |
// |              hi_i/lo_i/wide_i/neg_hi_i/neg_lo_i -> hi_o/lo_o                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             is_signed_i,
  output logic [WIDTH-1:0] a_abs_o,
  output logic [WIDTH-1:0] b_abs_o,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             wide_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] wide_neg;

  always_comb begin
    a_abs_o  = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_abs_o  = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    wide_neg = -{hi_i, lo_i};
    if (wide_i) begin
      // Product: negate across both halves so the borrow propagates into HI.
      {hi_o, lo_o} = neg_lo_i ? wide_neg : {hi_i, lo_i};
    end else begin
      hi_o = neg_hi_i ? -hi_i : hi_i;
      lo_o = neg_lo_i ? -lo_i : lo_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : muldiv_unit                                                   |
// | Purpose    : Multi-cycle multiply/divide with HI/LO registers. Iterative   |
// |              shift-add multiply and restoring divide, WIDTH+2 cycles.      |
// | Ports      : clk, rst (async, active-high), start, op[2:0], rs_val,        |
// |              rt_val, flush -> busy, done, div_by_zero, hi, lo, mul_result  |
// | Config     : MULDIV_FAST_MUL_EN - single-cycle multiplier for MULT/MULTU/  |
// |              MUL (result one edge after acceptance, never busy).           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mul_result
);

  localparam int ACC_W = acc_width(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2:0]         op_q, op_d;
  logic               qneg_q, qneg_d;     // product / quotient negative
  logic               rneg_q, rneg_d;     // remainder negative
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mres_q, mres_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  logic               in_signed, div_q_op;
  logic [WIDTH-1:0]   rs_abs, rt_abs, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_cand, div_diff;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL);
  assign div_q_op  = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a_i         (rs_val),
    .b_i         (rt_val),
    .is_signed_i (in_signed),
    .a_abs_o     (rs_abs),
    .b_abs_o     (rt_abs),
    .hi_i        (acc_q[ACC_W-1:WIDTH]),
    .lo_i        (acc_q[WIDTH-1:0]),
    .wide_i      (!div_q_op),
    .neg_hi_i    (rneg_q),
    .neg_lo_i    (qneg_q),
    .hi_o        (fix_hi),
    .lo_o        (fix_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic               fv_q, fv_d, fmul_q, fmul_d;
  logic [ACC_W-1:0]   fprod_q, fprod_d, fast_a, fast_b, fast_prod;
  // Sign-extend to full width; the low 2*WIDTH bits of the unsigned product
  // are then the correct two's-complement product.
  assign fast_a    = {{WIDTH{in_signed & rs_val[WIDTH-1]}}, rs_val};
  assign fast_b    = {{WIDTH{in_signed & rt_val[WIDTH-1]}}, rt_val};
  assign fast_prod = fast_a * fast_b;
`endif

  // Iteration datapath: shift-add keeps the multiplier in the low half and
  // shifts right; restoring divide shifts the dividend out of the low half
  // into the partial remainder while quotient bits fill in from the bottom.
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_cand = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_cand - {1'b0, opnd_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mres_d  = mres_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fv_d    = 1'b0;
    fprod_d = fprod_q;
    fmul_d  = fmul_q;
    // Retire the previous fast multiply first so a same-edge MTHI/MTLO wins.
    if (fv_q) begin
      if (fmul_q) mres_d = fprod_q[WIDTH-1:0];
      else        {hi_d, lo_d} = fprod_q;
      done_d = 1'b1;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_DIV, OP_DIVU: begin
              if (rt_val == '0) begin
                dbz_d = 1'b1;
              end else begin
                op_d    = op;
                cnt_d   = '0;
                qneg_d  = in_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                rneg_d  = in_signed && rs_val[WIDTH-1];
                opnd_d  = rt_abs;
                acc_d   = {{WIDTH{1'b0}}, rs_abs};
                state_d = ST_RUN;
              end
            end
            OP_MULT, OP_MULTU, OP_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
              fv_d    = 1'b1;
              fprod_d = fast_prod;
              fmul_d  = (op == OP_MUL);
`else
              op_d    = op;
              cnt_d   = '0;
              qneg_d  = in_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              rneg_d  = 1'b0;
              opnd_d  = rs_abs;
              acc_d   = {{WIDTH{1'b0}}, rt_abs};
              state_d = ST_RUN;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (div_q_op) begin
            if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                  acc_d = {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          if (op_q == OP_MUL) begin
            mres_d = fix_lo;
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mres_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fv_q    <= 1'b0;
      fprod_q <= '0;
      fmul_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mres_q  <= mres_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef MULDIV_FAST_MUL_EN
      fv_q    <= fv_d;
      fprod_q <= fprod_d;
      fmul_q  <= fmul_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mul_result  = mres_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It executes the operations the ALU decoder flags through `mul_en`, `div_en`/`start_div`, `mthi`/`mtlo` and `DivByZero`, which were previously single-cycle. It sits beside the EX-stage ALU. It drives `busy` so the hazard unit stalls, and exposes HI/LO for MFHI/MFLO forwarding.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `CNT_W`, default $clog2(WIDTH+1): width of the iteration counter.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: operation request, sampled on the rising edge.
- `op` input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MUL (rd form); 111 reserved and ignored.
- `rs_val` input, WIDTH bits: multiplicand / dividend / MTHI/MTLO source.
- `rt_val` input, WIDTH bits: multiplier / divisor.
- `flush` input, 1 bit: synchronous abort of an in-flight operation.
- `busy` output, 1 bit: operation in flight; new `start` is ignored.
- `done` output, 1 bit: one-cycle pulse on completion of MULT/MULTU/DIV/DIVU/MUL.
- `div_by_zero` output, 1 bit: one-cycle pulse when DIV/DIVU is accepted with `rt_val` == 0.
- `hi` output, WIDTH bits: HI register.
- `lo` output, WIDTH bits: LO register.
- `mul_result` output, WIDTH bits: low product of the last MUL, held until the next MUL completes.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - `start` with MULT/MULTU/DIV/DIVU/MUL: latch the operand magnitudes (signed ops take the absolute value), the result signs and the op; clear the counter; go to RUN.
  - `start` with MTHI/MTLO: write `rs_val` to HI or LO on that edge and stay in IDLE. No `done` pulse.
  - `start` with DIV/DIVU and `rt_val` == 0: HI/LO unchanged, `div_by_zero` pulses, stay in IDLE. No `done` pulse.
- **RUN**: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- **FIX**: negate the results where the signs require it. Then:
  - MULT/MULTU: {HI,LO} ← product.
  - DIV/DIVU: LO ← quotient, HI ← remainder.
  - MUL: `mul_result` ← low WIDTH bits of the product; HI/LO untouched.
  - Pulse `done` and return to IDLE.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Signed DIV of MIN by −1: LO = MIN (wrap), HI = 0.
  - All arithmetic is modulo 2^WIDTH per half.
- `start` while `busy`: ignored entirely.
- `flush` in RUN or FIX: go to IDLE at the next edge. HI/LO/`mul_result` unchanged, no `done`. `flush` in IDLE: no effect.
- `flush` and `start` in the same IDLE cycle: `start` wins.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `div_by_zero` 0, `hi` 0, `lo` 0, `mul_result` 0, counter 0.
- Reset mid-operation aborts immediately; nothing is written.
- Iterative latency:
  - `start` accepted at edge E0.
  - `busy` is 1 from E0 until edge E0+WIDTH+1.
  - HI/LO are written and `done` = 1 for the cycle following edge E0+WIDTH+1, with `busy` 0 in that same cycle.
  - Total: WIDTH+2 cycles, i.e. 34 for WIDTH=32.
- Back-to-back: a new `start` is accepted in the cycle `done` is high.
- MTHI/MTLO: 1-cycle latency; the new value is visible on `hi`/`lo` after the sampling edge.
- `div_by_zero`: pulses in the cycle after the sampling edge.
- `hi`/`lo`/`mul_result`: direct register outputs, no combinational paths from the inputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU/MUL are computed with a single-cycle WIDTH×WIDTH multiplier.
  - Result and `done` appear after edge E0+1; `busy` is never asserted for multiplies.
  - Divides remain iterative.
- `MULDIV_FAST_MUL_EN` undefined: every multiply uses the iterative RUN/FIX path with WIDTH+2 cycles of latency.

## Structure
- `muldiv_pkg` holds:
  - the `op` encoding localparams (OP_MULT … OP_MUL);
  - the FSM state typedef (IDLE/RUN/FIX);
  - the 2·WIDTH accumulator width constant.
- Sub-module `muldiv_sign_fix`: combinational absolute-value-in and conditional-negate-out for the quotient/remainder/product. It is shared by the latch and FIX stages.

## Test plan
- Reset mid-RUN (assert `rst` at cycle 10 of a DIV) → all outputs 0, state IDLE, no `done`.
- MULT, `rs_val`=0xFFFFFFFE (−2), `rt_val`=3 → after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` pulses once; MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU by 0 with HI=0x11, LO=0x22 → `div_by_zero` pulse, HI/LO unchanged, `busy` stays 0, no `done`.
- MTHI 0xDEAD then MTLO 0xBEEF on consecutive cycles → `hi`=0xDEAD, `lo`=0xBEEF one cycle after each; `start` during `busy` → ignored and the in-flight result is correct.
- `flush` at cycle 5 of MULT → `busy` 0 next cycle, HI/LO unchanged; with `MULDIV_FAST_MUL_EN`, MUL 6×7 → `mul_result`=42 and `done` one cycle later, `busy` never 1.
